dma_channel_engine: RTL and testbench
=====================================

# dma_channel_engine

Per-channel DMA transfer engine: the consumer side of the channel mode register. It latches the 6-bit mode word when service begins, then runs the bus-request and hold-acknowledge handshake with the CPU. It sequences the memory and I/O strobes, steps the current address and count registers, and signals terminal count. One instance sits behind each channel, between the mode/base registers and the system bus.

## Interface
- ADDR_W, 16, address register width
- CNT_W, 16, count register width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- mode_in  in  6  mode word: [5:4] service mode (00 demand, 01 single, 10 block, 11 cascade), [3] 1=decrement/0=increment, [2] autoinit, [1:0] type (00 verify, 01 write I/O→mem, 10 read mem→I/O, 11 treated as verify)
- base_addr  in  ADDR_W  base address
- base_cnt  in  CNT_W  base count (transfers = base_cnt+1)
- load  in  1  one-cycle pulse: base and current regs ← base inputs, clears mask
- dreq  in  1  device request, active high
- hlda  in  1  hold acknowledge from CPU
- eop_n  in  1  external end-of-process, active low
- hrq  out  1  hold request to CPU
- dack  out  1  device acknowledge
- addr_out  out  ADDR_W  current address
- cur_cnt  out  CNT_W  current count
- memr_n, memw_n, ior_n, iow_n  out  1 each  bus strobes, active low
- tc  out  1  one-cycle terminal-count pulse
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, REQ, S1, S2, S3, S4. Cascade mode uses IDLE/REQ only.
- Mask bit: set at reset and at TC/EOP without autoinit. Cleared by load. A masked channel ignores dreq.
- IDLE: if dreq & !mask, latch mode_in into mode_q, set hrq, go to REQ. mode_q is held for the whole service. Later mode_in changes do not affect it.
- REQ: hrq=1.
  - hlda=1 → S1.
  - dreq=0 before hlda in demand/single mode → IDLE with hrq=0.
  - Block mode keeps the request once latched.
- Cascade (mode_q=11): in REQ, hrq tracks dreq and dack tracks hlda, each registered one cycle. No strobes, no counting. Returns to IDLE when dreq=0.
- S1: dack=1 and addr_out valid. If hlda=0, go back to REQ (hrq stays 1, dack=0).
- S2: source strobe low (read: memr_n; write: ior_n).
- S3: source and destination strobes low (read: memr_n+iow_n; write: ior_n+memw_n).
- Verify type: no strobes in any state. Timing and counting are unchanged.
- S4: all strobes high. Address ±1 (mod 2^ADDR_W). Count −1 (mod 2^CNT_W).
- Terminal count: count was 0 at S4, so it wraps to all-ones. tc pulses in that cycle.
- End event = TC, or eop_n=0 sampled in any of S2–S4. On an end event:
  - autoinit=1: current regs ← base regs.
  - autoinit=0: mask set.
  - Then → IDLE, hrq=0, dack=0.
- S4 without an end event:
  - single → IDLE, drop hrq. Re-request no earlier than the next IDLE cycle.
  - block → S1.
  - demand → S1 if dreq=1, else IDLE (drop hrq).
- load while busy: accepted. Registers update at that edge. The transfer in flight continues with the new current values.

## Timing
- Reset values: hrq=0, dack=0, all strobes=1, tc=0, busy=0, addr_out=0, cur_cnt=0, mask=1, state=IDLE.
- rst_n low at any edge, including mid-transfer: reset values at that edge. No strobe stays asserted.
- dreq→hrq: 1 cycle (IDLE edge).
- hlda→dack: 1 cycle (REQ→S1).
- One transfer = 4 cycles (S1–S4). A block of N+1 transfers with hlda held occupies 4(N+1) cycles after S1 entry.
- All outputs are registered. tc is high only in the cycle after the S4 edge that wraps the count.
- load and S4 update on the same edge: load wins.
- eop_n and end-event TC on the same cycle: a single end event, tc=1.

## Test plan
- Reset, then load base_addr=0x1000, base_cnt=2, mode 10_0_0_10 (block, inc, read), dreq=1, hlda 1 cycle after hrq → 3 transfers. Addresses 0x1000/0x1001/0x1002. memr_n+iow_n low in S3. tc at 3rd S4. cur_cnt=0xFFFF. mask=1, hrq=0.
- Single mode, write, dreq held high, base_cnt=1 → hrq drops after each transfer and reasserts. 2 services total. ior_n/memw_n strobes only.
- Demand mode, decrement, base_addr=0x0000: drop dreq after the 2nd S4 → IDLE. Address wraps 0x0000→0xFFFF→0xFFFE. Count 5→3. No tc.
- Autoinit, base_cnt=0 → tc after 1 transfer. Current regs reload to base. mask stays 0. Next dreq starts a new service.
- eop_n=0 pulse during S2 of block transfer #2 → terminates after that S4. tc=0, mask=1.
- rst_n low during S3 → next edge: strobes high, hrq=0, state IDLE, mask=1. Cascade check: dreq→hrq and hlda→dack each 1-cycle registered, no strobes.

Source files
------------

// File: rtl/dma_channel_engine.sv
// Per-channel DMA transfer engine: latches the channel mode at service start, runs the
// hrq/hlda handshake, sequences the bus strobes, and steps the address/count registers.
//
// state | meaning
// IDLE  | no service; waits for an unmasked dreq
// REQ   | hrq asserted, waiting for hlda (cascade: pass-through handshake)
// S1    | dack asserted, address valid
// S2    | source strobe low
// S3    | source and destination strobes low
// S4    | strobes released; address/count step; end-event decision
module dma_channel_engine #(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [5:0]        mode_in,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  base_cnt,
   input  logic              load,
   input  logic              dreq,
   input  logic              hlda,
   input  logic              eop_n,
   output logic              hrq,
   output logic              dack,
   output logic [ADDR_W-1:0] addr_out,
   output logic [CNT_W-1:0]  cur_cnt,
   output logic              memr_n,
   output logic              memw_n,
   output logic              ior_n,
   output logic              iow_n,
   output logic              tc,
   output logic              busy
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_REQ, ST_S1, ST_S2, ST_S3, ST_S4
   } state_t;

   localparam logic [1:0] SVC_DEMAND  = 2'b00;
   localparam logic [1:0] SVC_SINGLE  = 2'b01;
   localparam logic [1:0] SVC_BLOCK   = 2'b10;
   localparam logic [1:0] SVC_CASCADE = 2'b11;
   localparam logic [1:0] TYP_WRITE   = 2'b01;
   localparam logic [1:0] TYP_READ    = 2'b10;

   state_t             state_q, state_d;
   logic [5:0]         mode_q, mode_d;
   logic               mask_q, mask_d;
   logic               eop_pend_q, eop_pend_d;
   logic [ADDR_W-1:0]  base_addr_q, base_addr_d;
   logic [CNT_W-1:0]   base_cnt_q, base_cnt_d;
   logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
   logic [CNT_W-1:0]   cur_cnt_q, cur_cnt_d;
   logic               hrq_q, hrq_d;
   logic               dack_q, dack_d;
   logic               memr_n_q, memr_n_d;
   logic               memw_n_q, memw_n_d;
   logic               ior_n_q, ior_n_d;
   logic               iow_n_q, iow_n_d;
   logic               tc_q, tc_d;
   logic               busy_q, busy_d;
   logic               tc_hit;
   logic               end_evt;

   assign tc_hit  = (cur_cnt_q == '0);
   assign end_evt = tc_hit | eop_pend_q | ~eop_n;

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      mask_d      = mask_q;
      eop_pend_d  = eop_pend_q;
      base_addr_d = base_addr_q;
      base_cnt_d  = base_cnt_q;
      cur_addr_d  = cur_addr_q;
      cur_cnt_d   = cur_cnt_q;
      tc_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            eop_pend_d = 1'b0;
            if (dreq && !mask_q) begin
               mode_d  = mode_in;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mode_q[5:4] == SVC_CASCADE) begin
               if (!dreq) state_d = ST_IDLE;
            end else if (hlda) begin
               state_d = ST_S1;
            end else if (!dreq && mode_q[5:4] != SVC_BLOCK) begin
               state_d = ST_IDLE;
            end
         end
         ST_S1: state_d = hlda ? ST_S2 : ST_REQ;
         ST_S2: begin
            state_d = ST_S3;
            if (!eop_n) eop_pend_d = 1'b1;
         end
         ST_S3: begin
            state_d = ST_S4;
            if (!eop_n) eop_pend_d = 1'b1;
         end
         ST_S4: begin
            eop_pend_d = 1'b0;
            cur_addr_d = mode_q[3] ? cur_addr_q - ADDR_W'(1) : cur_addr_q + ADDR_W'(1);
            cur_cnt_d  = cur_cnt_q - CNT_W'(1);
            if (end_evt) begin
               tc_d    = tc_hit;
               state_d = ST_IDLE;
               if (mode_q[2]) begin
                  cur_addr_d = base_addr_q;
                  cur_cnt_d  = base_cnt_q;
               end else begin
                  mask_d = 1'b1;
               end
            end else begin
               case (mode_q[5:4])
                  SVC_BLOCK:  state_d = ST_S1;
                  SVC_DEMAND: state_d = dreq ? ST_S1 : ST_IDLE;
                  default:    state_d = ST_IDLE;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A load on the same edge as an S4 step overrides the step.
      if (load) begin
         base_addr_d = base_addr;
         base_cnt_d  = base_cnt;
         cur_addr_d  = base_addr;
         cur_cnt_d   = base_cnt;
         mask_d      = 1'b0;
      end

      busy_d   = (state_d != ST_IDLE);
      hrq_d    = busy_d;
      dack_d   = (state_d == ST_S1) || (state_d == ST_S2) ||
                 (state_d == ST_S3) || (state_d == ST_S4) ||
                 (state_d == ST_REQ && mode_d[5:4] == SVC_CASCADE && hlda);
      memr_n_d = 1'b1;
      memw_n_d = 1'b1;
      ior_n_d  = 1'b1;
      iow_n_d  = 1'b1;
      if (state_d == ST_S2 || state_d == ST_S3) begin
         if (mode_d[1:0] == TYP_READ) begin
            memr_n_d = 1'b0;
            iow_n_d  = (state_d != ST_S3);
         end else if (mode_d[1:0] == TYP_WRITE) begin
            ior_n_d  = 1'b0;
            memw_n_d = (state_d != ST_S3);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mode_q      <= '0;
         mask_q      <= 1'b1;
         eop_pend_q  <= 1'b0;
         base_addr_q <= '0;
         base_cnt_q  <= '0;
         cur_addr_q  <= '0;
         cur_cnt_q   <= '0;
         hrq_q       <= 1'b0;
         dack_q      <= 1'b0;
         memr_n_q    <= 1'b1;
         memw_n_q    <= 1'b1;
         ior_n_q     <= 1'b1;
         iow_n_q     <= 1'b1;
         tc_q        <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         mask_q      <= mask_d;
         eop_pend_q  <= eop_pend_d;
         base_addr_q <= base_addr_d;
         base_cnt_q  <= base_cnt_d;
         cur_addr_q  <= cur_addr_d;
         cur_cnt_q   <= cur_cnt_d;
         hrq_q       <= hrq_d;
         dack_q      <= dack_d;
         memr_n_q    <= memr_n_d;
         memw_n_q    <= memw_n_d;
         ior_n_q     <= ior_n_d;
         iow_n_q     <= iow_n_d;
         tc_q        <= tc_d;
         busy_q      <= busy_d;
      end
   end

   assign hrq      = hrq_q;
   assign dack     = dack_q;
   assign addr_out = cur_addr_q;
   assign cur_cnt  = cur_cnt_q;
   assign memr_n   = memr_n_q;
   assign memw_n   = memw_n_q;
   assign ior_n    = ior_n_q;
   assign iow_n    = iow_n_q;
   assign tc       = tc_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_dma_channel_engine.sv
// Directed bench for dma_channel_engine: cycle-by-cycle expected bus vectors
// {hrq,dack,memr_n,memw_n,ior_n,iow_n,tc,busy} plus address/count.
module tb_dma_channel_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  mode_in = '0;
   logic [15:0] base_addr = '0;
   logic [15:0] base_cnt = '0;
   logic        load = 1'b0;
   logic        dreq = 1'b0;
   logic        hlda = 1'b0;
   logic        eop_n = 1'b1;
   logic        hrq, dack, memr_n, memw_n, ior_n, iow_n, tc, busy;
   logic [15:0] addr_out, cur_cnt;

   int checks = 0;
   int fails  = 0;

   localparam logic [7:0] V_IDLE   = 8'b0011_1100;
   localparam logic [7:0] V_IDLETC = 8'b0011_1110;
   localparam logic [7:0] V_REQ    = 8'b1011_1101;
   localparam logic [7:0] V_ACT    = 8'b1111_1101;
   localparam logic [7:0] V_RD_S2  = 8'b1101_1101;
   localparam logic [7:0] V_RD_S3  = 8'b1101_1001;
   localparam logic [7:0] V_WR_S2  = 8'b1111_0101;
   localparam logic [7:0] V_WR_S3  = 8'b1110_0101;

   dma_channel_engine #(.ADDR_W(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .base_addr(base_addr),
      .base_cnt(base_cnt), .load(load), .dreq(dreq), .hlda(hlda), .eop_n(eop_n),
      .hrq(hrq), .dack(dack), .addr_out(addr_out), .cur_cnt(cur_cnt),
      .memr_n(memr_n), .memw_n(memw_n), .ior_n(ior_n), .iow_n(iow_n),
      .tc(tc), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic [7:0] exp);
      chk(tag, {24'h0, hrq, dack, memr_n, memw_n, ior_n, iow_n, tc, busy}, {24'h0, exp});
   endtask

   task automatic do_load(input logic [5:0] m, input logic [15:0] a, input logic [15:0] c);
      mode_in = m; base_addr = a; base_cnt = c; load = 1'b1;
      tick();
      load = 1'b0;
      chk("load_addr", {16'h0, addr_out}, {16'h0, a});
      chk("load_cnt", {16'h0, cur_cnt}, {16'h0, c});
   endtask

   initial begin
      // reset
      tick(); tick();
      chk_bus("reset_bus", V_IDLE);
      chk("reset_addr", {16'h0, addr_out}, 32'h0);
      chk("reset_cnt", {16'h0, cur_cnt}, 32'h0);
      rst_n = 1'b1;
      dreq = 1'b1;
      tick();
      chk_bus("masked_after_reset", V_IDLE);

      // block, increment, read, 3 transfers
      do_load(6'b10_0_0_10, 16'h1000, 16'd2);
      tick();
      chk_bus("blk_req", V_REQ);
      hlda = 1'b1;
      tick();
      for (int t = 0; t < 3; t++) begin
         chk_bus("blk_s1", V_ACT);
         chk("blk_addr", {16'h0, addr_out}, 32'h1000 + t);
         chk("blk_cnt", {16'h0, cur_cnt}, 32'd2 - t);
         tick(); chk_bus("blk_s2", V_RD_S2);
         tick(); chk_bus("blk_s3", V_RD_S3);
         tick(); chk_bus("blk_s4", V_ACT);
         tick();
      end
      chk_bus("blk_tc", V_IDLETC);
      chk("blk_end_cnt", {16'h0, cur_cnt}, 32'hFFFF);
      chk("blk_end_addr", {16'h0, addr_out}, 32'h1003);
      tick();
      chk_bus("blk_masked", V_IDLE);

      // single, write, 2 services with hrq dropping between
      do_load(6'b01_0_0_01, 16'h2000, 16'd1);
      for (int s = 0; s < 2; s++) begin
         tick(); chk_bus("sgl_req", V_REQ);
         tick(); chk_bus("sgl_s1", V_ACT);
         chk("sgl_addr", {16'h0, addr_out}, 32'h2000 + s);
         tick(); chk_bus("sgl_s2", V_WR_S2);
         tick(); chk_bus("sgl_s3", V_WR_S3);
         tick(); chk_bus("sgl_s4", V_ACT);
         tick(); chk_bus("sgl_idle", (s == 1) ? V_IDLETC : V_IDLE);
      end
      chk("sgl_end_cnt", {16'h0, cur_cnt}, 32'hFFFF);
      tick();
      chk_bus("sgl_masked", V_IDLE);

      // demand, decrement, address wrap, dreq dropped in 2nd S4
      do_load(6'b00_1_0_10, 16'h0000, 16'd5);
      tick(); chk_bus("dem_req", V_REQ);
      tick(); chk_bus("dem_s1a", V_ACT);
      tick(); tick(); tick();
      tick(); chk_bus("dem_s1b", V_ACT);
      chk("dem_addr_wrap", {16'h0, addr_out}, 32'hFFFF);
      chk("dem_cnt4", {16'h0, cur_cnt}, 32'd4);
      tick(); chk_bus("dem_s2", V_RD_S2);
      tick(); tick(); chk_bus("dem_s4", V_ACT);
      dreq = 1'b0;
      tick();
      chk_bus("dem_idle_no_tc", V_IDLE);
      chk("dem_addr", {16'h0, addr_out}, 32'hFFFE);
      chk("dem_cnt", {16'h0, cur_cnt}, 32'd3);

      // autoinit, verify, base_cnt=0
      do_load(6'b10_0_1_00, 16'h3000, 16'd0);
      dreq = 1'b1;
      tick(); chk_bus("ai_req", V_REQ);
      tick(); chk_bus("ai_s1", V_ACT);
      tick(); chk_bus("ai_s2_nostrobe", V_ACT);
      tick(); chk_bus("ai_s3_nostrobe", V_ACT);
      tick(); chk_bus("ai_s4", V_ACT);
      tick(); chk_bus("ai_tc", V_IDLETC);
      chk("ai_reload_addr", {16'h0, addr_out}, 32'h3000);
      chk("ai_reload_cnt", {16'h0, cur_cnt}, 32'h0);
      tick(); chk_bus("ai_rerequest", V_REQ);
      tick(); tick(); tick(); tick(); tick();
      chk_bus("ai_tc2", V_IDLETC);
      dreq = 1'b0;
      tick();
      chk_bus("ai_idle", V_IDLE);

      // external EOP during S2 of block transfer #2
      do_load(6'b10_0_0_10, 16'h4000, 16'd3);
      dreq = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      tick(); chk_bus("eop_s1b", V_ACT);
      chk("eop_addr2", {16'h0, addr_out}, 32'h4001);
      tick(); chk_bus("eop_s2", V_RD_S2);
      eop_n = 1'b0;
      tick(); chk_bus("eop_s3", V_RD_S3);
      eop_n = 1'b1;
      tick(); chk_bus("eop_s4", V_ACT);
      tick();
      chk_bus("eop_end_no_tc", V_IDLE);
      chk("eop_addr", {16'h0, addr_out}, 32'h4002);
      chk("eop_cnt", {16'h0, cur_cnt}, 32'd1);
      tick();
      chk_bus("eop_masked", V_IDLE);

      // reset during S3
      do_load(6'b10_0_0_10, 16'h5000, 16'd3);
      tick(); tick(); tick();
      tick(); chk_bus("rst_pre_s3", V_RD_S3);
      rst_n = 1'b0;
      tick();
      chk_bus("rst_mid_bus", V_IDLE);
      chk("rst_mid_addr", {16'h0, addr_out}, 32'h0);
      rst_n = 1'b1;
      tick();
      chk_bus("rst_mid_masked", V_IDLE);

      // cascade pass-through
      hlda = 1'b0;
      dreq = 1'b0;
      do_load(6'b11_0_0_00, 16'h6000, 16'd7);
      dreq = 1'b1;
      tick(); chk_bus("cas_req", V_REQ);
      hlda = 1'b1;
      tick(); chk_bus("cas_dack", V_ACT);
      tick(); chk_bus("cas_hold", V_ACT);
      hlda = 1'b0;
      tick(); chk_bus("cas_dack_drop", V_REQ);
      dreq = 1'b0;
      tick(); chk_bus("cas_idle", V_IDLE);
      chk("cas_cnt_static", {16'h0, cur_cnt}, 32'd7);
      chk("cas_addr_static", {16'h0, addr_out}, 32'h6000);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
